// File: rtl/mole_timer_pkg.sv
// -----------------------------------------------------------------------------
// mole_timer_pkg
//   Shared definitions for the multi-mole timer:
//     - LVL_EASY / LVL_MED / LVL_HARD / LVL_INSANE : 2-bit level encodings
//     - chan_state_e                               : per-channel IDLE/RUN state
//     - STREAK_W                                   : width of the streak counter
//     - ticks_for_level()                          : mole lifetime for a level,
//                                                    reduced by the hit streak
// -----------------------------------------------------------------------------
package mole_timer_pkg;

  localparam logic [1:0] LVL_EASY   = 2'd0;
  localparam logic [1:0] LVL_MED    = 2'd1;
  localparam logic [1:0] LVL_HARD   = 2'd2;
  localparam logic [1:0] LVL_INSANE = 2'd3;

  localparam int STREAK_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } chan_state_e;

  // Lifetime in ticks for a level. A table entry of 0 is promoted to 1 so a
  // mole is always visible for at least one tick, and the streak can shorten
  // the lifetime down to, but never below, one tick.
  function automatic int unsigned ticks_for_level(
    input logic [1:0]          lvl,
    input logic [STREAK_W-1:0] streak,
    input int unsigned         t0,
    input int unsigned         t1,
    input int unsigned         t2,
    input int unsigned         t3
  );
    int unsigned base;
    int unsigned s;
    s = 32'(streak);
    case (lvl)
      LVL_EASY: base = t0;
      LVL_MED:  base = t1;
      LVL_HARD: base = t2;
      default:  base = t3;
    endcase
    if (base == 0) base = 1;
    if (base > s) base = base - s;
    else          base = 1;
    return base;
  endfunction

endpackage

// File: rtl/mole_timer_channel.sv
// -----------------------------------------------------------------------------
// mole_timer_channel
//   One mole slot: a two-state FSM (IDLE/RUN), a tick counter and the lifetime
//   limit latched when the mole spawns.
//
//   Ports:
//     clk_game      in   game tick clock
//     rst_n         in   asynchronous active-low reset
//     enable        in   game running; low forces IDLE without pulses
//     pause         in   freezes the counter while RUN
//     level  [1:0]  in   difficulty, latched on start
//     streak [2:0]  in   current hit streak (0 when the speed-up is not built)
//     start         in   one-cycle spawn pulse
//     hit           in   one-cycle button pulse
//     state         out  FSM state (active = state == RUN)
//     timeout_pulse out  registered one-cycle expiry pulse
//     hit_ok        out  registered one-cycle successful-hit pulse
//     timeout_next  out  combinational value about to load into timeout_pulse,
//                        so the top can register timeout_any on the same edge
// -----------------------------------------------------------------------------
module mole_timer_channel
  import mole_timer_pkg::*;
#(
  parameter int          CNT_W    = 32,
  parameter int unsigned TICKS_L0 = 10,
  parameter int unsigned TICKS_L1 = 7,
  parameter int unsigned TICKS_L2 = 4,
  parameter int unsigned TICKS_L3 = 2
) (
  input  logic                clk_game,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                pause,
  input  logic [1:0]          level,
  input  logic [STREAK_W-1:0] streak,
  input  logic                start,
  input  logic                hit,
  output chan_state_e         state,
  output logic                timeout_pulse,
  output logic                hit_ok,
  output logic                timeout_next
);

  localparam logic [63:0]      CNT_MAX = (64'd1 << CNT_W) - 64'd1;
  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  // Keep the limit representable in CNT_W bits so the counter can reach
  // limit-1 without wrapping.
  function automatic logic [CNT_W-1:0] clamp_limit(input int unsigned t);
    logic [63:0] w;
    w = {32'd0, t};
    if (w > CNT_MAX) w = CNT_MAX;
    return w[CNT_W-1:0];
  endfunction

  localparam logic [CNT_W-1:0] RESET_LIMIT =
    clamp_limit(ticks_for_level(LVL_EASY, '0, TICKS_L0, TICKS_L1, TICKS_L2, TICKS_L3));

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic             hit_ok_d;

  always_ff @(posedge clk_game or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      count_q       <= '0;
      limit_q       <= RESET_LIMIT;
      timeout_pulse <= 1'b0;
      hit_ok        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      limit_q       <= limit_d;
      timeout_pulse <= timeout_next;
      hit_ok        <= hit_ok_d;
    end
  end

  // Priority: disable > start (restart) > hit > pause > count/expire.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    limit_d      = limit_q;
    timeout_next = 1'b0;
    hit_ok_d     = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      count_d = '0;
    end else if (start) begin
      state_d = RUN;
      count_d = '0;
      limit_d = clamp_limit(ticks_for_level(level, streak,
                                            TICKS_L0, TICKS_L1, TICKS_L2, TICKS_L3));
    end else if (state_q == RUN) begin
      if (hit) begin
        hit_ok_d = 1'b1;
        state_d  = IDLE;
        count_d  = '0;
      end else if (pause) begin
        count_d = count_q;
      end else if (count_q >= limit_q - ONE) begin
        // limit_q is never 0, so limit_q - 1 cannot underflow.
        timeout_next = 1'b1;
        state_d      = IDLE;
        count_d      = '0;
      end else begin
        count_d = count_q + ONE;
      end
    end
  end

  assign state = state_q;

endmodule

// File: rtl/multi_mole_timer.sv
// -----------------------------------------------------------------------------
// multi_mole_timer
//   NUM_MOLES independent mole lifetime timers between the mole generator and
//   the scoring/LED logic, all in the clk_game domain. Every pulse output is
//   registered and appears one cycle after the input that caused it.
//
//   Ports:
//     clk_game                 in   game tick clock
//     rst_n                    in   asynchronous active-low reset
//     enable                   in   game running; 0 clears all channels
//     pause                    in   freeze all counters
//     level         [1:0]      in   difficulty, latched per channel at start
//     start         [N-1:0]    in   spawn pulse per channel
//     hit           [N-1:0]    in   debounced button pulse per channel
//     active        [N-1:0]    out  mole lit / timer running
//     timeout_pulse [N-1:0]    out  mole expired
//     hit_ok        [N-1:0]    out  active mole hit
//     miss_pulse               out  a hit landed on an unlit channel
//     timeout_any              out  OR of timeout_pulse, same cycle
//     streak        [2:0]      out  saturating hit streak (only when
//                                   MOLE_STREAK_SPEEDUP_EN is defined)
//
//   Build option MOLE_STREAK_SPEEDUP_EN: a 3-bit streak counter shortens the
//   lifetime of newly spawned moles by one tick per consecutive hit.
// -----------------------------------------------------------------------------
module multi_mole_timer
  import mole_timer_pkg::*;
#(
  parameter int          NUM_MOLES = 4,
  parameter int          CNT_W     = 32,
  parameter int unsigned TICKS_L0  = 10,
  parameter int unsigned TICKS_L1  = 7,
  parameter int unsigned TICKS_L2  = 4,
  parameter int unsigned TICKS_L3  = 2
) (
  input  logic                 clk_game,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 pause,
  input  logic [1:0]           level,
  input  logic [NUM_MOLES-1:0] start,
  input  logic [NUM_MOLES-1:0] hit,
  output logic [NUM_MOLES-1:0] active,
  output logic [NUM_MOLES-1:0] timeout_pulse,
  output logic [NUM_MOLES-1:0] hit_ok,
  output logic                 miss_pulse,
  output logic                 timeout_any
`ifdef MOLE_STREAK_SPEEDUP_EN
  ,
  output logic [STREAK_W-1:0]  streak
`endif
);

  chan_state_e                 chan_state [NUM_MOLES];
  logic [NUM_MOLES-1:0]        timeout_next;
  logic [STREAK_W-1:0]         streak_val;
  logic                        miss_d;

  for (genvar i = 0; i < NUM_MOLES; i++) begin : g_chan
    mole_timer_channel #(
      .CNT_W    (CNT_W),
      .TICKS_L0 (TICKS_L0),
      .TICKS_L1 (TICKS_L1),
      .TICKS_L2 (TICKS_L2),
      .TICKS_L3 (TICKS_L3)
    ) u_chan (
      .clk_game      (clk_game),
      .rst_n         (rst_n),
      .enable        (enable),
      .pause         (pause),
      .level         (level),
      .streak        (streak_val),
      .start         (start[i]),
      .hit           (hit[i]),
      .state         (chan_state[i]),
      .timeout_pulse (timeout_pulse[i]),
      .hit_ok        (hit_ok[i]),
      .timeout_next  (timeout_next[i])
    );
    assign active[i] = (chan_state[i] == RUN);
  end

  // A hit on an unlit channel is a miss, unless the same channel is spawning
  // this cycle (the spawn wins) or the game is disabled.
  assign miss_d = |(hit & ~active & ~start & {NUM_MOLES{enable}});

  always_ff @(posedge clk_game or negedge rst_n) begin
    if (!rst_n) begin
      miss_pulse  <= 1'b0;
      timeout_any <= 1'b0;
    end else begin
      miss_pulse  <= miss_d;
      timeout_any <= |timeout_next;
    end
  end

`ifdef MOLE_STREAK_SPEEDUP_EN
  logic [STREAK_W-1:0] streak_q;

  // Updated from the registered pulses, so a new value takes effect on spawns
  // one cycle after the pulse. Any loss (timeout or miss) beats a hit.
  always_ff @(posedge clk_game or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= '0;
    end else if ((|timeout_pulse) || miss_pulse) begin
      streak_q <= '0;
    end else if ((|hit_ok) && (streak_q != {STREAK_W{1'b1}})) begin
      streak_q <= streak_q + 1'b1;
    end
  end

  assign streak     = streak_q;
  assign streak_val = streak_q;
`else
  assign streak_val = '0;
`endif

endmodule

// File: tb/tb_multi_mole_timer.sv
// -----------------------------------------------------------------------------
// tb_multi_mole_timer
//   Directed vector table, hand-written corner sequences and a randomized run
//   against a remaining-lifetime reference model of the mole timers.
// -----------------------------------------------------------------------------
module tb_multi_mole_timer;

  localparam int N = 4;

  logic         clk_game = 1'b0;
  logic         rst_n    = 1'b0;
  logic         enable   = 1'b0;
  logic         pause    = 1'b0;
  logic [1:0]   level    = 2'd0;
  logic [N-1:0] start    = '0;
  logic [N-1:0] hit      = '0;
  logic [N-1:0] active, timeout_pulse, hit_ok;
  logic         miss_pulse, timeout_any;
`ifdef MOLE_STREAK_SPEEDUP_EN
  logic [2:0]   streak;
`endif

  multi_mole_timer #(
    .NUM_MOLES (N),
    .CNT_W     (32),
    .TICKS_L0  (10),
    .TICKS_L1  (7),
    .TICKS_L2  (4),
    .TICKS_L3  (2)
  ) dut (
    .clk_game      (clk_game),
    .rst_n         (rst_n),
    .enable        (enable),
    .pause         (pause),
    .level         (level),
    .start         (start),
    .hit           (hit),
    .active        (active),
    .timeout_pulse (timeout_pulse),
    .hit_ok        (hit_ok),
    .miss_pulse    (miss_pulse),
    .timeout_any   (timeout_any)
`ifdef MOLE_STREAK_SPEEDUP_EN
    ,
    .streak        (streak)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk_game = ~clk_game;

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act !== expv)
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    else
      n_pass++;
  endtask

  // ---------------- reference model ----------------
  // Each lit mole carries the number of unpaused ticks it has left.
  bit           m_run [N];
  int           m_rem [N];
  logic [N-1:0] m_act, m_to, m_hok;
  logic         m_miss, m_tany;
  int           m_streak;

  function automatic int life(input logic [1:0] l, input int s);
    int t;
    case (l)
      2'd0:    t = 10;
      2'd1:    t = 7;
      2'd2:    t = 4;
      default: t = 2;
    endcase
    if (t == 0) t = 1;
    return (t > s) ? t - s : 1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_run[c] = 1'b0;
      m_rem[c] = 0;
    end
    m_act = '0; m_to = '0; m_hok = '0; m_miss = 1'b0; m_tany = 1'b0;
    m_streak = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] old_to, old_hok;
    logic         old_miss;
    old_to = m_to; old_hok = m_hok; old_miss = m_miss;
    m_to = '0; m_hok = '0; m_miss = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (hit[c] && !m_run[c] && enable && !start[c]) m_miss = 1'b1;
      if (!enable) begin
        m_run[c] = 1'b0;
      end else if (start[c]) begin
        m_run[c] = 1'b1;
        m_rem[c] = life(level, m_streak);
      end else if (m_run[c]) begin
        if (hit[c]) begin
          m_hok[c] = 1'b1;
          m_run[c] = 1'b0;
        end else if (!pause) begin
          if (m_rem[c] <= 1) begin
            m_to[c]  = 1'b1;
            m_run[c] = 1'b0;
          end else begin
            m_rem[c]--;
          end
        end
      end
      m_act[c] = m_run[c];
    end
    m_tany = |m_to;
`ifdef MOLE_STREAK_SPEEDUP_EN
    if ((|old_to) || old_miss) m_streak = 0;
    else if ((|old_hok) && m_streak < 7) m_streak++;
`else
    if (old_miss && (|old_to) && (|old_hok)) m_streak = 0;
`endif
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_active"},  32'(active),        32'(m_act));
    chk({tag, "_timeout"}, 32'(timeout_pulse), 32'(m_to));
    chk({tag, "_hit_ok"},  32'(hit_ok),        32'(m_hok));
    chk({tag, "_miss"},    32'(miss_pulse),    32'(m_miss));
    chk({tag, "_tany"},    32'(timeout_any),   32'(m_tany));
`ifdef MOLE_STREAK_SPEEDUP_EN
    chk({tag, "_streak"},  32'(streak),        32'(m_streak));
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic en, input logic pz, input logic [1:0] lv,
                       input logic [N-1:0] st, input logic [N-1:0] ht);
    enable = en; pause = pz; level = lv; start = st; hit = ht;
  endtask

  // One clock: outputs are sampled 1 ns after the edge, model follows.
  task automatic tick(input string tag);
    @(posedge clk_game);
    #1;
    model_step();
    compare_all(tag);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 2'd0, '0, '0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk_game);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Ticks after the current one until timeout_pulse[ch] is seen, -1 if never.
  task automatic wait_timeout(input int ch, input int budget, input string tag,
                              output int lat);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      tick(tag);
      if (timeout_pulse[ch] === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         en;
    logic         pz;
    logic [1:0]   lv;
    logic [N-1:0] st;
    logic [N-1:0] ht;
    logic [N-1:0] e_act;
    logic [N-1:0] e_to;
    logic [N-1:0] e_hok;
    logic         e_miss;
    logic         e_tany;
  } vec_t;

  localparam int NV = 10;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic en, input logic pz, input logic [1:0] lv,
                              input logic [N-1:0] st, input logic [N-1:0] ht,
                              input logic [N-1:0] ea, input logic [N-1:0] eto,
                              input logic [N-1:0] eh, input logic em, input logic et);
    vec_t v;
    v.en = en; v.pz = pz; v.lv = lv; v.st = st; v.ht = ht;
    v.e_act = ea; v.e_to = eto; v.e_hok = eh; v.e_miss = em; v.e_tany = et;
    return v;
  endfunction

  // ---------------- main test ----------------
  initial begin
    int lat;
    model_reset();

    // Reset state
    #2;
    chk("rst_active",  32'(active),        32'd0);
    chk("rst_timeout", 32'(timeout_pulse), 32'd0);
    chk("rst_hit_ok",  32'(hit_ok),        32'd0);
    chk("rst_miss",    32'(miss_pulse),    32'd0);
    chk("rst_tany",    32'(timeout_any),   32'd0);
    do_reset();

    //          en pz lv     start    hit      active   timeout  hit_ok  miss  tany
    tbl[0] = mk(1, 0, 2'd2, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 0, 0);
    tbl[1] = mk(1, 0, 2'd2, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 0, 0);
    tbl[2] = mk(1, 0, 2'd2, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 0, 0);
    tbl[3] = mk(1, 0, 2'd0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1, 0);
    tbl[4] = mk(1, 0, 2'd3, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0, 0);
    tbl[5] = mk(1, 0, 2'd0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 0, 0);
    tbl[6] = mk(1, 0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 0, 1);
    tbl[7] = mk(1, 0, 2'd0, 4'b1100, 4'b0000, 4'b1100, 4'b0000, 4'b0000, 0, 0);
    tbl[8] = mk(0, 0, 2'd0, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    tbl[9] = mk(1, 0, 2'd0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1, 0);

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].en, tbl[i].pz, tbl[i].lv, tbl[i].st, tbl[i].ht);
      @(posedge clk_game);
      #1;
      chk($sformatf("vec%0d_active", i),  32'(active),        32'(tbl[i].e_act));
      chk($sformatf("vec%0d_timeout", i), 32'(timeout_pulse), 32'(tbl[i].e_to));
      chk($sformatf("vec%0d_hit_ok", i),  32'(hit_ok),        32'(tbl[i].e_hok));
      chk($sformatf("vec%0d_miss", i),    32'(miss_pulse),    32'(tbl[i].e_miss));
      chk($sformatf("vec%0d_tany", i),    32'(timeout_any),   32'(tbl[i].e_tany));
    end

    // Level 0 lifetime: 10 ticks from spawn to the timeout pulse.
    do_reset();
    drive(1, 0, 2'd0, 4'b0001, '0);
    tick("l0_start");
    drive(1, 0, 2'd0, '0, '0);
    wait_timeout(0, 30, "l0_run", lat);
    chk("l0_lifetime", 32'(lat), 32'd10);
    tick("l0_after");
    chk("l0_inactive_after", 32'(active[0]), 32'd0);

    // Level 1 with a 5-cycle pause: 7 + 5 = 12.
    drive(1, 0, 2'd1, 4'b0100, '0);
    tick("pz_start");
    drive(1, 0, 2'd1, '0, '0);
    tick("pz_run"); tick("pz_run");
    drive(1, 1, 2'd1, '0, '0);
    repeat (5) tick("pz_hold");
    drive(1, 0, 2'd1, '0, '0);
    wait_timeout(2, 30, "pz_run2", lat);
    chk("pause_lifetime", 32'(lat + 7), 32'd12);

    // Restart on the tick that would expire: no pulse, fresh 10 ticks.
    drive(1, 0, 2'd0, 4'b1000, '0);
    tick("rs_start");
    drive(1, 0, 2'd0, '0, '0);
    repeat (9) tick("rs_run");
    drive(1, 0, 2'd0, 4'b1000, '0);
    tick("rs_restart");
    chk("restart_no_timeout", 32'(timeout_pulse[3]), 32'd0);
    chk("restart_active",     32'(active[3]),        32'd1);
    drive(1, 0, 2'd0, '0, '0);
    wait_timeout(3, 30, "rs_run2", lat);
    chk("restart_lifetime", 32'(lat), 32'd10);

    // Hit on the tick that would expire: hit_ok only.
    drive(1, 0, 2'd3, 4'b0001, '0);
    tick("ht_start");
    drive(1, 0, 2'd3, '0, '0);
    tick("ht_run");
    drive(1, 0, 2'd3, '0, 4'b0001);
    tick("ht_hit");
    chk("hit_vs_timeout_hok", 32'(hit_ok[0]),        32'd1);
    chk("hit_vs_timeout_to",  32'(timeout_pulse[0]), 32'd0);

    // Disable with two moles lit.
    drive(1, 0, 2'd0, 4'b0011, '0);
    tick("en_start");
    drive(1, 0, 2'd0, '0, '0);
    tick("en_run");
    drive(0, 0, 2'd0, '0, 4'b0001);
    tick("en_drop");
    chk("disable_active",  32'(active),        32'd0);
    chk("disable_timeout", 32'(timeout_pulse), 32'd0);
    chk("disable_miss",    32'(miss_pulse),    32'd0);

`ifdef MOLE_STREAK_SPEEDUP_EN
    // Three hits at level 2 leave a one-tick lifetime; the timeout clears it.
    do_reset();
    for (int h = 0; h < 3; h++) begin
      drive(1, 0, 2'd2, 4'b0010, '0);
      tick("sk_start");
      drive(1, 0, 2'd2, '0, 4'b0010);
      tick("sk_hit");
      drive(1, 0, 2'd2, '0, '0);
      tick("sk_idle");
    end
    chk("streak_three", 32'(streak), 32'd3);
    drive(1, 0, 2'd2, 4'b0010, '0);
    tick("sk_fast");
    drive(1, 0, 2'd2, '0, '0);
    tick("sk_expire");
    chk("streak_fast_timeout", 32'(timeout_pulse[1]), 32'd1);
    tick("sk_clear");
    chk("streak_cleared", 32'(streak), 32'd0);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int r = 0; r < 400; r++) begin
      logic [N-1:0] st, ht;
      for (int c = 0; c < N; c++) begin
        st[c] = ($urandom_range(0, 7) == 0);
        ht[c] = ($urandom_range(0, 5) == 0);
      end
      drive(($urandom_range(0, 19) != 0), ($urandom_range(0, 7) == 0),
            2'($urandom_range(0, 3)), st, ht);
      tick("rnd");
    end

    // Asynchronous reset in the middle of a run.
    drive(1, 0, 2'd0, 4'b1111, '0);
    tick("mr_start");
    drive(1, 0, 2'd0, '0, '0);
    repeat (3) tick("mr_run");
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_active",  32'(active),        32'd0);
    chk("midrst_timeout", 32'(timeout_pulse), 32'd0);
    chk("midrst_miss",    32'(miss_pulse),    32'd0);
    #3;
    rst_n = 1'b1;
    model_reset();
    tick("mr_after");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout_guard actual=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/multi_mole_timer.md
Name: multi_mole_timer

Overview:
- N-channel successor to the single-mole difficulty timer. Each mole slot gets an independent timeout counter, so several moles can be lit at once.
- Each channel adds early cancel on hit, hit/miss qualification, a global pause, and a per-channel level latched at spawn.
- Sits between the mole generator (start pulses) and the scoring/LED logic (timeout, hit, miss pulses) in the clk_game domain.

Parameters:
- NUM_MOLES, 4, number of independent channels (1..16)
- CNT_W, 32, tick counter width
- TICKS_L0, 10, lifetime in clk_game ticks at level 0 (easy)
- TICKS_L1, 7, lifetime at level 1 (medium)
- TICKS_L2, 4, lifetime at level 2 (hard)
- TICKS_L3, 2, lifetime at level 3 (insane)

Ports:
- clk_game  in  1  game tick clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  game running; 0 clears all channels
- pause  in  1  freeze all counters; state is held
- level  in  2  difficulty, sampled per channel at start
- start  in  NUM_MOLES  one-cycle spawn pulse per channel
- hit  in  NUM_MOLES  one-cycle debounced button pulse per channel
- active  out  NUM_MOLES  mole lit / timer running
- timeout_pulse  out  NUM_MOLES  one-cycle pulse when a mole expires
- hit_ok  out  NUM_MOLES  one-cycle pulse when an active mole is hit
- miss_pulse  out  1  one-cycle pulse when any hit lands on an inactive channel
- timeout_any  out  1  OR of timeout_pulse, registered alongside it

Behaviour:
- Reset: all counters 0, latched levels 0; active, timeout_pulse, hit_ok, miss_pulse and timeout_any all 0.
- All pulse outputs default to 0 every cycle and are registered, so each appears one cycle after the causing input.
- Per-channel FSM has two states, IDLE and RUN; active = (state == RUN).
- Priority per channel, evaluated each cycle:
  - !enable: go to IDLE, count = 0, no pulses; hit is ignored and does not produce a miss.
  - start: count = 0, latch level, go to RUN. Wins over a hit or timeout in the same cycle (restart); no hit_ok or timeout_pulse is emitted.
  - hit in RUN: hit_ok = 1, go to IDLE, count = 0. Wins over a timeout in the same cycle.
  - hit in IDLE: contributes to miss_pulse.
  - pause in RUN: count holds, no timeout. pause does not block start or hit.
  - RUN otherwise: if count >= limit - 1, then timeout_pulse = 1, go to IDLE, count = 0; else count + 1.
- Limit comes from the latched level: L0..L3 map to TICKS_L0..TICKS_L3.
  - A TICKS value of 0 is treated as 1.
  - Lifetime is exactly TICKS_Lx unpaused cycles from the cycle after start to the cycle timeout_pulse is high.
- Arithmetic is CNT_W unsigned. The limit is clamped to 2^CNT_W - 1, so the counter never wraps.
- miss_pulse = OR over channels of (hit & ~active & enable & ~start).
- Changing level mid-run does not affect running channels.
- Reset mid-run: asynchronous clear of all state; no pulses emitted.

Optional Feature:
- Macro: MOLE_STREAK_SPEEDUP_EN.
- Enabled:
  - Adds a 3-bit saturating streak counter: incremented on any hit_ok, cleared on any timeout_pulse or miss_pulse.
  - Effective limit = max(1, TICKS_Lx - streak), computed at start and latched per channel.
  - Adds output streak [2:0].
- Disabled: no streak logic, no streak port; the limit is exactly TICKS_Lx.

Decomposition:
- Package mole_timer_pkg holds:
  - level encoding constants LVL_EASY, LVL_MED, LVL_HARD, LVL_INSANE
  - channel state enum IDLE/RUN
  - function ticks_for_level(level, streak) implementing the clamp rules
- Sub-module mole_timer_channel: one FSM + counter + latched limit, instantiated NUM_MOLES times by a generate loop.
- The top level owns miss_pulse, timeout_any and the optional streak counter.

Test Plan:
- Level 0, start[0] at cycle 0, no hit -> active[0] = 1 from cycle 1; timeout_pulse[0] = 1 at cycle 10 only; active[0] = 0 at cycle 11.
- Level 2 start[1]; at cycle 2 assert hit[1] -> hit_ok[1] = 1 at cycle 3; timeout_pulse[1] never asserts.
- Level 1 start[2]; pause high for 5 cycles mid-run -> timeout_pulse[2] arrives 7 + 5 = 12 cycles after start.
- start[3] in the same cycle its timeout would fire -> no timeout_pulse[3]; counter restarts and expires TICKS later. Same for hit + timeout in the same cycle -> hit_ok only.
- hit[0] while channel 0 is IDLE -> miss_pulse = 1 one cycle later. Drop enable with two moles active -> active = 0 next cycle, no pulses.
- With MOLE_STREAK_SPEEDUP_EN, level 2, three consecutive hits -> next start gives a lifetime of 1 tick; a following timeout resets streak to 0.
